butterfly_result_serializer: RTL and testbench

Downstream stage of butterfly2. It captures one butterfly result (two complex Q-format words) on the butterfly done pulse and streams it byte-by-byte into UART_TX using UART_TX's start/done handshake. It replaces the ad-hoc byte counter, mux and start-retrigger glue with one registered FSM. It also reports frame completion and dropped results.

---
 rtl/butterfly_result_serializer.sv | 126 ++++++++++++
 tb/tb_butterfly_result_serializer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_result_serializer.sv
// Captures one butterfly2 result (four WORD_SIZE words) on i_valid and streams it to
// UART_TX one byte at a time over the start/done handshake, LSB byte of each word first.
module butterfly_result_serializer #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [WORD_SIZE-1:0] i_out0_re,
  input  logic [WORD_SIZE-1:0] i_out0_im,
  input  logic [WORD_SIZE-1:0] i_out1_re,
  input  logic [WORD_SIZE-1:0] i_out1_im,
  input  logic                 i_TX_done,
  output logic                 o_TX_start,
  output logic [7:0]           o_TX_byte,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_overrun
);

  localparam int BYTES_PER_WORD = WORD_SIZE / 8;
  localparam int NUM_BYTES      = 4 * BYTES_PER_WORD;
  localparam int IDX_W          = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int FRAME_W        = 4 * WORD_SIZE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [FRAME_W-1:0]   shadow_q, shadow_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 overrun_q, overrun_d;

  logic [7:0]           frame_bytes [NUM_BYTES];

  // Word k occupies shadow bits [k*WORD_SIZE +: WORD_SIZE], so byte k*BPW+j is a plain slice.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BYTES; b++) begin
      frame_bytes[b] = shadow_d[8*b +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          shadow_d   = {i_out1_im, i_out1_re, i_out0_im, i_out0_re};
          byte_idx_d = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (i_valid) overrun_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_valid) overrun_d = 1'b1;
        if (i_TX_done) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
            state_d    = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet still line up
  // with the state they describe (start high exactly during the SEND cycle).
  always_comb begin
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    busy_d     = (state_d != ST_IDLE);
    if (state_d == ST_SEND) begin
      tx_start_d = 1'b1;
      tx_byte_d  = frame_bytes[byte_idx_d];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= '0;
      shadow_q     <= '0;
      tx_start_q   <= 1'b0;
      tx_byte_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      shadow_q     <= shadow_d;
      tx_start_q   <= tx_start_d;
      tx_byte_q    <= tx_byte_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_TX_start   = tx_start_q;
  assign o_TX_byte    = tx_byte_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_butterfly_result_serializer.sv
// Directed bench for butterfly_result_serializer with a UART_TX responder that
// answers each start with a done pulse 10 cycles later.
module tb_butterfly_result_serializer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [15:0] i_out0_re, i_out0_im, i_out1_re, i_out1_im;
  logic        i_TX_done;
  logic        o_TX_start;
  logic [7:0]  o_TX_byte;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_overrun;

  butterfly_result_serializer #(.WORD_SIZE(16)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_out0_re    (i_out0_re),
    .i_out0_im    (i_out0_im),
    .i_out1_re    (i_out1_re),
    .i_out1_im    (i_out1_im),
    .i_TX_done    (i_TX_done),
    .o_TX_start   (o_TX_start),
    .o_TX_byte    (o_TX_byte),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_overrun    (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] re0;
    logic [15:0] im0;
    logic [15:0] re1;
    logic [15:0] im1;
    logic [63:0] exp;   // expected bytes in send order, first byte in the top 8 bits
  } vec_t;

  vec_t vec [4];

  int passed = 0;
  int total  = 0;

  // Responder / monitor state (written at #2 after each edge; main works at #1)
  int         nstart       = 0;
  int         fd_cnt       = 0;
  int         stab_err     = 0;
  int         timing_err   = 0;
  int         countdown    = 0;
  bit         done_pending = 1'b0;
  bit         inject       = 1'b0;
  logic [7:0] cur_byte     = 8'h00;
  logic [7:0] got [$];

  int fd0;
  int n0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] exp_byte(input int e, input int i);
    logic [63:0] x;
    x = vec[e].exp;
    return x[63-8*i -: 8];
  endfunction

  initial begin
    i_TX_done = 1'b0;
    forever begin
      @(posedge i_clk);
      #2;
      i_TX_done = 1'b0;
      if (o_frame_done) fd_cnt++;
      if (i_rst) begin
        countdown    = 0;
        done_pending = 1'b0;
      end else begin
        if (done_pending) begin
          done_pending = 1'b0;
          if (!(o_TX_start || o_frame_done)) timing_err++;
        end
        if (countdown > 0) begin
          countdown--;
          if (o_TX_start || (o_TX_byte !== cur_byte)) stab_err++;
          if (countdown == 0) begin
            i_TX_done    = 1'b1;
            done_pending = 1'b1;
          end
        end else if (o_TX_start) begin
          nstart++;
          got.push_back(o_TX_byte);
          cur_byte  = o_TX_byte;
          countdown = 9;
          if (inject) i_TX_done = 1'b1;
        end
      end
    end
  end

  task automatic begin_frame();
    got.delete();
    fd0        = fd_cnt;
    n0         = nstart;
    stab_err   = 0;
    timing_err = 0;
  endtask

  // Called at #1 after an edge; returns at #1 after the capture edge.
  task automatic apply(input int e, input string tag);
    i_out0_re = vec[e].re0;
    i_out0_im = vec[e].im0;
    i_out1_re = vec[e].re1;
    i_out1_im = vec[e].im1;
    i_valid   = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    check({tag, " start_latency"}, 64'({o_TX_start, o_busy}), 64'b11);
    check({tag, " first_byte"}, 64'(o_TX_byte), 64'(exp_byte(e, 0)));
  endtask

  task automatic check_bytes(input int e, input string tag);
    logic [7:0] b;
    check({tag, " byte_count"}, 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      b = (i < got.size()) ? got[i] : 8'hxx;
      check($sformatf("%s byte%0d", tag, i), 64'(b), 64'(exp_byte(e, i)));
    end
  endtask

  task automatic wait_starts(input int n, input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(posedge i_clk);
      #1;
      if (nstart - n0 >= n) ok = 1'b1;
    end
    check({tag, " reached_start"}, 64'(ok), 64'd1);
  endtask

  task automatic end_frame(input int e, input logic exp_ovr, input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(posedge i_clk);
      #1;
      if (o_frame_done) ok = 1'b1;
    end
    check({tag, " frame_done_seen"}, 64'(ok), 64'd1);
    check({tag, " busy_at_done"}, 64'(o_busy), 64'd0);
    check({tag, " overrun"}, 64'(o_overrun), 64'(exp_ovr));
    check({tag, " last_byte_held"}, 64'(o_TX_byte), 64'(exp_byte(e, 7)));
    check_bytes(e, tag);
    @(posedge i_clk);
    #1;
    check({tag, " frame_done_width"}, 64'(o_frame_done), 64'd0);
    check({tag, " frame_done_count"}, 64'(fd_cnt - fd0), 64'd1);
    check({tag, " wait_stability"}, 64'(stab_err), 64'd0);
    check({tag, " done_to_start"}, 64'(timing_err), 64'd0);
  endtask

  initial begin
    vec[0] = '{16'h0500, 16'h0000, 16'hFF00, 16'h0200, 64'h00_05_00_00_00_FF_00_02};
    vec[1] = '{16'h1234, 16'hABCD, 16'h0001, 16'h8000, 64'h34_12_CD_AB_01_00_00_80};
    vec[2] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 64'h00_01_00_02_00_03_00_04};
    vec[3] = '{16'hA55A, 16'h00FF, 16'h7F80, 16'hFFFF, 64'h5A_A5_FF_00_80_7F_FF_FF};

    i_rst     = 1'b1;
    i_valid   = 1'b0;
    i_out0_re = '0;
    i_out0_im = '0;
    i_out1_re = '0;
    i_out1_im = '0;
    #1;
    check("reset outputs", 64'({o_TX_start, o_TX_byte, o_busy, o_frame_done, o_overrun}), 64'd0);
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check("idle after release", 64'({o_TX_start, o_busy, o_overrun}), 64'd0);

    for (int e = 0; e < 4; e++) begin
      begin_frame();
      apply(e, $sformatf("vec%0d", e));
      end_frame(e, 1'b0, $sformatf("vec%0d", e));
      repeat (3) @(posedge i_clk);
      #1;
    end

    // Second result arrives during byte 3, inputs then change mid-frame
    begin_frame();
    apply(0, "t3");
    wait_starts(4, "t3");
    i_out0_re = vec[1].re0;
    i_out0_im = vec[1].im0;
    i_out1_re = vec[1].re1;
    i_out1_im = vec[1].im1;
    i_valid   = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid   = 1'b0;
    i_out0_re = 16'hDEAD;
    i_out1_im = 16'hBEEF;
    check("t3 overrun_set", 64'(o_overrun), 64'd1);
    end_frame(0, 1'b1, "t3");
    repeat (20) @(posedge i_clk);
    #1;
    check("t3 overrun_sticky", 64'(o_overrun), 64'd1);
    check("t3 no_extra_frame", 64'({o_busy, 32'(nstart - n0)}), 64'd8);

    // Reset during WAIT of byte 4
    begin_frame();
    apply(1, "t4a");
    wait_starts(5, "t4a");
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    check("t4 async_reset outputs", 64'({o_TX_start, o_TX_byte, o_busy, o_frame_done, o_overrun}), 64'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    n0 = nstart;
    repeat (30) @(posedge i_clk);
    #1;
    check("t4 no_start_after_release", 64'(nstart - n0), 64'd0);
    check("t4 idle_after_release", 64'({o_TX_start, o_busy, o_frame_done}), 64'd0);
    begin_frame();
    apply(2, "t4b");
    end_frame(2, 1'b0, "t4b");

    // i_valid coincident with the final i_TX_done
    begin_frame();
    apply(3, "t5");
    begin
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
        @(posedge i_clk);
        #1;
        if ((nstart - n0 == 8) && (countdown == 1)) ok = 1'b1;
      end
      check("t5 reached_final_wait", 64'(ok), 64'd1);
    end
    i_out0_re = vec[0].re0;
    i_out0_im = vec[0].im0;
    i_out1_re = vec[0].re1;
    i_out1_im = vec[0].im1;
    i_valid   = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    check("t5 frame_done", 64'(o_frame_done), 64'd1);
    check("t5 busy", 64'(o_busy), 64'd0);
    check("t5 overrun", 64'(o_overrun), 64'd1);
    check_bytes(3, "t5");
    repeat (20) @(posedge i_clk);
    #1;
    check("t5 dropped", 64'({o_busy, 32'(nstart - n0)}), 64'd8);
    begin_frame();
    apply(0, "t5next");
    end_frame(0, 1'b1, "t5next");

    // Done pulse injected during each SEND cycle
    inject = 1'b1;
    begin_frame();
    apply(1, "t6");
    end_frame(1, 1'b1, "t6");
    inject = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
